imem_fetch_responder: RTL and testbench

- Instruction-memory responder: the other end of the PC fetch interface.
- The PC stage (pcplus4 / branch mux path) issues byte addresses. This block accepts them with a valid/ready handshake, reads a word-addressed instruction store, and returns instruction plus address to decode.
- A 2-entry response FIFO decouples decode stalls.
- A flush input discards in-flight fetches on a taken branch.

---
 rtl/imem_fetch_responder.sv | 165 ++++++++++++++++
 tb/tb_imem_fetch_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: accepts PC-stage byte addresses, reads a
// word-addressed instruction store and returns {instr, addr, fault} through a 2-entry FIFO.
module imem_fetch_responder #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_instr,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_fault,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = $clog2(DEPTH);
    localparam logic [IDX_W:0] DEPTH_L  = (IDX_W + 1)'(DEPTH);
    localparam logic [1:0]     FULL_CNT = 2'(FIFO_DEPTH);

    function automatic logic idx_oob(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} >= DEPTH_L);
    endfunction

    function automatic logic req_fault(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] != 2'b00) || idx_oob(addr[ADDR_W-1:2]);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] instr_q [2];
    logic [DATA_W-1:0] instr_d [2];
    logic [ADDR_W-1:0] addr_q  [2];
    logic [ADDR_W-1:0] addr_d  [2];
    logic [1:0]        fault_q;
    logic [1:0]        fault_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;

    logic [IDX_W-1:0]  rd_idx_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic              rd_fault_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              push_s;
    logic              pop_s;
    logic              unused_s;

    assign rd_idx_s   = req_addr[ADDR_W-1:2];
    assign wr_idx_s   = wr_addr[ADDR_W-1:2];
    assign rd_fault_s = req_fault(req_addr);
    assign unused_s   = ^wr_addr[1:0];

    // A flush frees the whole buffer, so the redirect target can always enter.
    assign req_ready  = flush || (count_q < FULL_CNT);
    assign resp_valid = (count_q != 2'd0);
    assign push_s     = req_valid && req_ready;
    assign pop_s      = resp_valid && resp_ready && !flush;

    // Store read; faulting fetches return a NOP word.
    always_comb begin
        rd_word_s = {DATA_W{1'b0}};
        if (rd_fault_s) begin
            rd_word_s = {DATA_W{1'b0}};
        end else begin
            rd_word_s = mem_q[rd_idx_s[MEM_AW-1:0]];
        end
    end

    // Program-load write port; the fetch path sees the pre-edge contents.
    always_ff @(posedge clk) begin
        if (wr_en && !idx_oob(wr_idx_s)) begin
            mem_q[wr_idx_s[MEM_AW-1:0]] <= wr_data;
        end
    end

    // FIFO next-state: flush resets the buffer and keeps only a same-cycle push.
    always_comb begin
        instr_d  = instr_q;
        addr_d   = addr_q;
        fault_d  = fault_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            if (push_s) begin
                instr_d[0] = rd_word_s;
                addr_d[0]  = req_addr;
                fault_d[0] = rd_fault_s;
                wr_ptr_d   = 1'b1;
                count_d    = 2'd1;
            end else begin
                wr_ptr_d = 1'b0;
                count_d  = 2'd0;
            end
        end else begin
            if (push_s) begin
                instr_d[wr_ptr_q] = rd_word_s;
                addr_d[wr_ptr_q]  = req_addr;
                fault_d[wr_ptr_q] = rd_fault_s;
                wr_ptr_d          = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= {DATA_W{1'b0}};
                addr_q[i]  <= {ADDR_W{1'b0}};
            end
            fault_q  <= 2'b00;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            instr_q  <= instr_d;
            addr_q   <= addr_d;
            fault_q  <= fault_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head presentation; outputs are forced to zero when the buffer is empty.
    always_comb begin
        resp_instr = {DATA_W{1'b0}};
        resp_addr  = {ADDR_W{1'b0}};
        resp_fault = 1'b0;
        if (resp_valid) begin
            resp_instr = instr_q[rd_ptr_q];
            resp_addr  = addr_q[rd_ptr_q];
            resp_fault = fault_q[rd_ptr_q];
        end else begin
            resp_instr = {DATA_W{1'b0}};
            resp_addr  = {ADDR_W{1'b0}};
            resp_fault = 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder (ADDR_W=9 build so 0x100 is an out-of-range fetch).
module tb_imem_fetch_responder;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          flush;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_instr;
    logic [AW-1:0] resp_addr;
    logic          resp_fault;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int n_cmp = 0;
    int n_err = 0;

    imem_fetch_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(64), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_instr(resp_instr), .resp_addr(resp_addr), .resp_fault(resp_fault),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic v, input logic [DW-1:0] ins,
                        input logic [AW-1:0] a, input logic f);
        chk({tag, "_valid"}, {31'd0, resp_valid}, {31'd0, v});
        chk({tag, "_instr"}, resp_instr, ins);
        chk({tag, "_addr"},  {23'd0, resp_addr}, {23'd0, a});
        chk({tag, "_fault"}, {31'd0, resp_fault}, {31'd0, f});
    endtask

    task automatic rdy(input string tag, input logic exp);
        chk(tag, {31'd0, req_ready}, {31'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 9'h000; flush = 1'b0;
        resp_ready = 1'b0; wr_en = 1'b0; wr_addr = 9'h000; wr_data = 32'h0;
        #3;
        head("rst", 1'b0, 32'h0, 9'h000, 1'b0);
        rdy("rst_ready", 1'b1);
        @(negedge clk); rst_n = 1'b1;

        // Program load
        wr_en = 1'b1; wr_addr = 9'h000; wr_data = 32'h20080005; step();
        wr_addr = 9'h004; wr_data = 32'h20090007; step();
        wr_addr = 9'h008; wr_data = 32'h01095020; step();
        wr_en = 1'b0;
        head("idle", 1'b0, 32'h0, 9'h000, 1'b0);

        // Stream with resp_ready high
        resp_ready = 1'b1; req_valid = 1'b1; req_addr = 9'h000; step();
        head("s0", 1'b1, 32'h20080005, 9'h000, 1'b0); rdy("s0_ready", 1'b1);
        req_addr = 9'h004; step();
        head("s1", 1'b1, 32'h20090007, 9'h004, 1'b0); rdy("s1_ready", 1'b1);
        req_addr = 9'h008; step();
        head("s2", 1'b1, 32'h01095020, 9'h008, 1'b0); rdy("s2_ready", 1'b1);
        req_valid = 1'b0; step();
        head("s_drain", 1'b0, 32'h0, 9'h000, 1'b0);

        // Backpressure
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 9'h000; step();
        head("bp0", 1'b1, 32'h20080005, 9'h000, 1'b0); rdy("bp0_ready", 1'b1);
        req_addr = 9'h004; step();
        head("bp1", 1'b1, 32'h20080005, 9'h000, 1'b0); rdy("bp1_full", 1'b0);
        req_addr = 9'h008; step();
        head("bp2", 1'b1, 32'h20080005, 9'h000, 1'b0); rdy("bp2_full", 1'b0);
        resp_ready = 1'b1; step();
        head("bp_pop", 1'b1, 32'h20090007, 9'h004, 1'b0); rdy("bp_pop_ready", 1'b1);
        resp_ready = 1'b0; step();
        head("bp_acc", 1'b1, 32'h20090007, 9'h004, 1'b0); rdy("bp_acc_full", 1'b0);
        req_valid = 1'b0; resp_ready = 1'b1; step();
        head("bp_d1", 1'b1, 32'h01095020, 9'h008, 1'b0);
        step();
        head("bp_d2", 1'b0, 32'h0, 9'h000, 1'b0);

        // Flush with a simultaneous redirect request
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 9'h000; step();
        req_addr = 9'h004; step();
        rdy("fl_full", 1'b0);
        flush = 1'b1; req_addr = 9'h008; #1;
        rdy("fl_ready", 1'b1);
        step();
        flush = 1'b0; req_valid = 1'b0;
        head("fl_head", 1'b1, 32'h01095020, 9'h008, 1'b0); rdy("fl_cnt1", 1'b1);
        resp_ready = 1'b1; step();
        head("fl_empty", 1'b0, 32'h0, 9'h000, 1'b0);

        // Faults
        req_valid = 1'b1; req_addr = 9'h002; step();
        head("f_mis", 1'b1, 32'h0, 9'h002, 1'b1);
        req_addr = 9'h100; step();
        head("f_oob", 1'b1, 32'h0, 9'h100, 1'b1);
        req_addr = 9'h004; step();
        head("f_ok", 1'b1, 32'h20090007, 9'h004, 1'b0);
        req_valid = 1'b0; step();

        // Read-before-write on the same index
        wr_en = 1'b1; wr_addr = 9'h004; wr_data = 32'hDEADBEEF;
        req_valid = 1'b1; req_addr = 9'h004; step();
        wr_en = 1'b0;
        head("rbw_old", 1'b1, 32'h20090007, 9'h004, 1'b0);
        step();
        head("rbw_new", 1'b1, 32'hDEADBEEF, 9'h004, 1'b0);
        req_valid = 1'b0; step();
        head("rbw_empty", 1'b0, 32'h0, 9'h000, 1'b0);

        // Async reset with two entries buffered
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 9'h000; step();
        req_addr = 9'h008; step();
        req_valid = 1'b0;
        head("ar_pre", 1'b1, 32'h20080005, 9'h000, 1'b0); rdy("ar_pre_full", 1'b0);
        #2 rst_n = 1'b0;
        #1;
        head("ar", 1'b0, 32'h0, 9'h000, 1'b0); rdy("ar_ready", 1'b1);
        @(negedge clk); rst_n = 1'b1;
        resp_ready = 1'b1; req_valid = 1'b1; req_addr = 9'h000; step();
        head("ar_refetch", 1'b1, 32'h20080005, 9'h000, 1'b0);
        req_valid = 1'b0; step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
